// File: rtl/pong_pkg.sv
// Shared match-state encodings, screen geometry and direction codes for the pong game-rule engine.
// Pure constants; no logic, no latency.
package pong_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int X_MIN_PADDLE = 2;
  localparam int X_MAX_PADDLE = 61;
  localparam int Y_MAX        = 63;
  localparam int PADDLE_H     = 6;
  localparam int CENTRE       = 32;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/pong_game_ctrl_score.sv
// Saturating per-player score counter: clear wins over increment, holds at WIN_SCORE.
// One-cycle update latency; term is a decode of the registered count.
module score_counter #(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] cnt,
  output logic               term
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  assign term = (cnt == WIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match FSM: turns per-frame collision events into ball direction, serve/recentre and scores.
// Events in a frame_tick cycle update the registered outputs at the next clk edge; no backpressure.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               paddle_hit,
  input  logic               wall_hit,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_en,
  output logic               ball_reset,
  output logic               dir_x,
  output logic               dir_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               point,
  output logic               game_over,
  output logic               winner
);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);

  logic [2:0]       state;
  logic [CNT_W-1:0] countdown;
  logic             term1;
  logic             term2;
  logic             tick_play;
  logic             clr_scores;
  logic             inc1;
  logic             inc2;

  assign tick_play  = (state == ST_PLAY) && frame_tick;
  assign clr_scores = ((state == ST_IDLE) || (state == ST_OVER)) && start;
  // miss_left has priority, so a double miss only credits player 2
  assign inc2       = tick_play && miss_left;
  assign inc1       = tick_play && !miss_left && miss_right;

  score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_scores), .inc(inc1), .cnt(score1), .term(term1)
  );

  score_counter #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) u_score2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_scores), .inc(inc2), .cnt(score2), .term(term2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      countdown  <= '0;
      ball_en    <= 1'b0;
      ball_reset <= 1'b0;
      dir_x      <= DIR_RIGHT;
      dir_y      <= DIR_DOWN;
      point      <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      point      <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          ball_en <= 1'b0;
          if (start) begin
            state      <= ST_SERVE;
            ball_reset <= 1'b1;
            countdown  <= SERVE_LOAD;
            game_over  <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (countdown <= 1) begin
              countdown <= '0;
              state     <= ST_PLAY;
              ball_en   <= 1'b1;
            end else begin
              countdown <= countdown - 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (miss_left || miss_right) begin
              // serve heads toward the player who conceded
              state      <= ST_POINT;
              point      <= 1'b1;
              ball_reset <= 1'b1;
              ball_en    <= 1'b0;
              dir_x      <= miss_left ? DIR_LEFT : DIR_RIGHT;
              dir_y      <= ~dir_y;
            end else begin
              if (paddle_hit) dir_x <= ~dir_x;
              if (wall_hit)   dir_y <= ~dir_y;
            end
          end
        end
        ST_POINT: begin
          if (term1 || term2) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            winner    <= !term1;
          end else begin
            state     <= ST_SERVE;
            countdown <= SERVE_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with SERVE_FRAMES=3, WIN_SCORE=7.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start, paddle_hit, wall_hit, miss_left, miss_right;
  logic       ball_en, ball_reset, dir_x, dir_y, point, game_over, winner;
  logic [3:0] score1, score2;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.WIN_SCORE(7), .SCORE_W(4), .SERVE_FRAMES(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .paddle_hit(paddle_hit), .wall_hit(wall_hit), .miss_left(miss_left), .miss_right(miss_right),
    .ball_en(ball_en), .ball_reset(ball_reset), .dir_x(dir_x), .dir_y(dir_y),
    .score1(score1), .score2(score2), .point(point), .game_over(game_over), .winner(winner)
  );

  // Drive one cycle of inputs, then settle #1 past the edge for sampling.
  task automatic step(input logic t, input logic s, input logic ph, input logic wh,
                      input logic ml, input logic mr);
    frame_tick = t; start = s; paddle_hit = ph; wall_hit = wh; miss_left = ml; miss_right = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic serve_to_play();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    checks++;
    if ({ball_en, ball_reset, dir_x, dir_y, point, game_over, winner} !== 7'b0011000) begin
      $display("FAIL reset_flags: got %b want 0011000",
               {ball_en, ball_reset, dir_x, dir_y, point, game_over, winner});
      fails++;
    end
    checks++;
    if ({score1, score2} !== 8'h00) begin
      $display("FAIL reset_scores: got %0d/%0d want 0/0", score1, score2); fails++;
    end
  endtask

  task automatic test_serve();
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if ({ball_reset, ball_en} !== 2'b10) begin
      $display("FAIL serve_start: ball_reset,ball_en=%b want 10", {ball_reset, ball_en}); fails++;
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (ball_reset !== 1'b0) begin
      $display("FAIL serve_pulse_len: ball_reset=%b want 0", ball_reset); fails++;
    end
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if ({ball_en, dir_x, dir_y} !== 3'b011) begin
      $display("FAIL serve_wait: ball_en,dir_x,dir_y=%b want 011", {ball_en, dir_x, dir_y}); fails++;
    end
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if ({ball_en, dir_x, dir_y} !== 3'b111) begin
      $display("FAIL serve_release: ball_en,dir_x,dir_y=%b want 111", {ball_en, dir_x, dir_y}); fails++;
    end
  endtask

  task automatic test_corner_hit();
    step(1, 0, 1, 1, 0, 0);
    checks++;
    if ({dir_x, dir_y} !== 2'b00) begin
      $display("FAIL corner_hit: dir=%b want 00", {dir_x, dir_y}); fails++;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
    checks++;
    if ({dir_x, dir_y, ball_en} !== 3'b001) begin
      $display("FAIL no_tick_hold: dir,ball_en=%b want 001", {dir_x, dir_y, ball_en}); fails++;
    end
  endtask

  task automatic test_miss_right();
    step(1, 0, 1, 0, 0, 1);
    checks++;
    if (score1 !== 4'd1) begin
      $display("FAIL miss_right_score: score1=%0d want 1", score1); fails++;
    end
    checks++;
    if ({point, ball_reset, ball_en, dir_x, dir_y} !== 5'b11011) begin
      $display("FAIL miss_right_flags: pt,rst,en,dx,dy=%b want 11011",
               {point, ball_reset, ball_en, dir_x, dir_y});
      fails++;
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if ({point, ball_reset, game_over} !== 3'b000) begin
      $display("FAIL point_one_cycle: pt,rst,go=%b want 000", {point, ball_reset, game_over}); fails++;
    end
    serve_to_play();
    checks++;
    if (ball_en !== 1'b1) begin
      $display("FAIL reserve: ball_en=%b want 1", ball_en); fails++;
    end
  endtask

  task automatic test_both_miss();
    step(1, 0, 0, 0, 1, 1);
    checks++;
    if ({score1, score2} !== {4'd1, 4'd1}) begin
      $display("FAIL both_miss: scores=%0d/%0d want 1/1", score1, score2); fails++;
    end
    checks++;
    if ({dir_x, dir_y} !== 2'b00) begin
      $display("FAIL both_miss_dir: dir=%b want 00", {dir_x, dir_y}); fails++;
    end
    step(0, 0, 0, 0, 0, 0);
    serve_to_play();
  endtask

  task automatic test_win_and_restart();
    for (int r = 0; r < 5; r++) begin
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      serve_to_play();
    end
    checks++;
    if ({score1, game_over, ball_en} !== {4'd6, 1'b0, 1'b1}) begin
      $display("FAIL pre_win: score1=%0d go=%b en=%b want 6,0,1", score1, game_over, ball_en); fails++;
    end
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if ({score1, game_over, winner, ball_en} !== {4'd7, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL win: score1=%0d go=%b win=%b en=%b want 7,1,0,0",
               score1, game_over, winner, ball_en);
      fails++;
    end
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    checks++;
    if ({score1, score2, game_over, winner} !== {4'd7, 4'd1, 1'b1, 1'b0}) begin
      $display("FAIL over_frozen: scores=%0d/%0d go=%b win=%b want 7/1,1,0",
               score1, score2, game_over, winner);
      fails++;
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if ({score1, score2, game_over, ball_reset} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      $display("FAIL restart: scores=%0d/%0d go=%b rst=%b want 0/0,0,1",
               score1, score2, game_over, ball_reset);
      fails++;
    end
    serve_to_play();
    checks++;
    if (ball_en !== 1'b1) begin
      $display("FAIL restart_play: ball_en=%b want 1", ball_en); fails++;
    end
  endtask

  task automatic test_reset_mid_play();
    for (int r = 0; r < 3; r++) begin
      step(1, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      serve_to_play();
    end
    checks++;
    if ({score1, score2, ball_en} !== {4'd0, 4'd3, 1'b1}) begin
      $display("FAIL pre_reset: scores=%0d/%0d en=%b want 0/3,1", score1, score2, ball_en); fails++;
    end
    rst_n = 1'b0;
    step(1, 1, 1, 1, 1, 1);
    rst_n = 1'b1;
    checks++;
    if ({ball_en, ball_reset, dir_x, dir_y, point, game_over, winner, score1, score2} !==
        {7'b0011000, 8'h00}) begin
      $display("FAIL mid_reset: outs=%b want 001100000000000",
               {ball_en, ball_reset, dir_x, dir_y, point, game_over, winner, score1, score2});
      fails++;
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    checks++;
    if ({ball_en, ball_reset} !== 2'b00) begin
      $display("FAIL idle_after_reset: en,rst=%b want 00", {ball_en, ball_reset}); fails++;
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (ball_reset !== 1'b1) begin
      $display("FAIL idle_start: ball_reset=%b want 1", ball_reset); fails++;
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 0; start = 0; paddle_hit = 0; wall_hit = 0;
    miss_left = 0; miss_right = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_serve();
    test_corner_hit();
    test_miss_right();
    test_both_miss();
    test_win_and_restart();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-rule engine. It consumes the per-frame hit/miss events from the collision detector and turns them into ball direction, serve/recentre commands and player scores.
- Sits between collision detection (upstream, event producer) and ball movement / display (downstream, command consumers).
- Owns the match state machine: idle, serve countdown, rally, point award, game over.

Parameters:
- WIN_SCORE, 7, points needed to win a match (1..2^SCORE_W-1)
- SCORE_W, 4, width of each score counter
- SERVE_FRAMES, 60, frame_tick count between recentre and ball release (>=1)
- CNT_W, 8, width of the serve countdown counter (must hold SERVE_FRAMES)

Ports:
- clk  in  1  system clock; the single clock domain
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-cycle pulse per video frame; event inputs are valid only in this cycle
- start  in  1  level; begins a match from IDLE or OVER
- paddle_hit  in  1  ball touched either paddle
- wall_hit  in  1  ball touched top row (y=0) or bottom row (y=63)
- miss_left  in  1  ball reached x=2 outside player-1 paddle span; player 2 scores
- miss_right  in  1  ball reached x=61 outside player-2 paddle span; player 1 scores
- ball_en  out  1  ball movement allowed to step this frame
- ball_reset  out  1  one-cycle pulse: recentre ball to (32,32)
- dir_x  out  1  0 = moving left, 1 = moving right
- dir_y  out  1  0 = moving up, 1 = moving down
- score1  out  SCORE_W  player-1 score
- score2  out  SCORE_W  player-2 score
- point  out  1  one-cycle pulse when a point is awarded
- game_over  out  1  high while in OVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over=1

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - State goes to IDLE.
  - ball_en=0, ball_reset=0, dir_x=1, dir_y=1, score1=score2=0, point=0, game_over=0, winner=0, countdown=0.
  - Reset overrides every other input in that cycle.
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE:
  - ball_en=0.
  - If start=1: clear both scores, pulse ball_reset for exactly that one cycle, load countdown=SERVE_FRAMES, go to SERVE next cycle.
- SERVE:
  - ball_en=0.
  - Each frame_tick decrements the countdown.
  - On the tick that makes the countdown 0, go to PLAY. ball_en=1 from the next cycle.
  - Event inputs are ignored in SERVE.
- PLAY:
  - ball_en=1. Inputs are evaluated only in cycles with frame_tick=1.
  - Priority: miss_left > miss_right > paddle_hit/wall_hit.
  - No miss: paddle_hit toggles dir_x; wall_hit toggles dir_y. If both are high, both toggle in the same cycle (corner hit).
  - miss_left: score2 += 1, point=1 for one cycle, go to POINT.
  - miss_right: score1 += 1, point=1 for one cycle, go to POINT.
  - Both misses high: treated as miss_left only.
- POINT (exactly one cycle):
  - ball_en=0, ball_reset=1.
  - Serve direction: dir_x points toward the player who conceded (miss_left -> dir_x=0; miss_right -> dir_x=1). dir_y inverts on every serve.
  - If the updated score equals WIN_SCORE: go to OVER, winner = scoring player.
  - Otherwise: load countdown=SERVE_FRAMES and go to SERVE.
- OVER:
  - game_over=1, ball_en=0, scores and winner frozen.
  - start=1 behaves as in IDLE: scores cleared, game_over drops the next cycle.
- Scores saturate at WIN_SCORE and never wrap.
- frame_tick is ignored outside SERVE and PLAY.
- Latency: event in a frame_tick cycle -> registered outputs update at the next clk edge (1 cycle).
- All outputs are registered.

Decomposition:
- Shared package `pong_pkg`:
  - state enum
  - screen constants: X_MIN_PADDLE=2, X_MAX_PADDLE=61, Y_MAX=63, PADDLE_H=6, CENTRE=32
  - DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN encodings
- One sub-module is natural: `score_counter`, a saturating SCORE_W incrementer with clear and terminal flag, instantiated twice.
- FSM and direction logic stay in the top module.

Test Plan:
- Reset then start=1, SERVE_FRAMES=3 -> ball_reset pulses once; ball_en=0 for 3 frame_ticks, ball_en=1 the cycle after the 3rd tick; dir_x=1, dir_y=1.
- PLAY, frame_tick with paddle_hit=1 and wall_hit=1 -> next cycle dir_x=0 and dir_y=0. The same inputs held high without frame_tick -> no change.
- PLAY, frame_tick with miss_right=1 and paddle_hit=1 -> score1 0->1, point pulse, dir_x=1 (toward player 2), dir_y inverted, dir_x not toggled by paddle_hit, ball_reset pulse, SERVE.
- Simultaneous miss_left=1 and miss_right=1 -> only score2 increments; score1 unchanged.
- WIN_SCORE=7: six rounds of miss_right, then a seventh -> score1=7, game_over=1, winner=0; further frame_ticks with miss inputs -> scores stay 7/x. Then start=1 -> scores 0/0, game_over=0, SERVE.
- rst_n=0 asserted for one cycle mid-PLAY with score2=3 -> every output returns to its reset value the following cycle; state IDLE.
